// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - CTRL_* : funct3-style size/sign codes accepted on req_ctrl
//   - lsu_state_t : sequencing states of the unit
//   - size_mask() : unshifted byte-enable mask for a ctrl code (0 when the
//                   code names no legal access size)
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] CTRL_B  = 3'b000;
  localparam logic [2:0] CTRL_H  = 3'b001;
  localparam logic [2:0] CTRL_W  = 3'b010;
  localparam logic [2:0] CTRL_BU = 3'b100;
  localparam logic [2:0] CTRL_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // An all-zero mask doubles as the "illegal encoding" marker.
  function automatic logic [3:0] size_mask(input logic [2:0] ctrl);
    logic [3:0] m;
    case (ctrl)
      CTRL_B, CTRL_BU: m = 4'b0001;
      CTRL_H, CTRL_HU: m = 4'b0011;
      CTRL_W:          m = 4'b1111;
      default:         m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data aligner. Takes up to two memory words of raw beat
// data (second word in the upper half), selects the addressed byte/half/word
// starting at the byte lane and sign- or zero-extends it to 32 bits.
// Used for both single-beat and split (two-beat) loads.
// Ports:
//   beat_data [63:0] in  {second word, first word}
//   lane      [1:0]  in  byte offset of the access inside the first word
//   ctrl      [2:0]  in  size/sign code (ctrl[2]=1 selects zero-extension)
//   result    [31:0] out extended load value
// -----------------------------------------------------------------------------
import lsu_pkg::*;

module lsu_load_align (
  input  logic [63:0] beat_data,
  input  logic [1:0]  lane,
  input  logic [2:0]  ctrl,
  output logic [31:0] result
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic zext);
    logic signed [31:0] s;
    s = {{24{b[7] & ~zext}}, b};
    return s;
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic zext);
    logic signed [31:0] s;
    s = {{16{h[15] & ~zext}}, h};
    return s;
  endfunction

  logic [31:0] win;

  // Bring the addressed lane down to bit 0; bytes past the first word come
  // from the second beat, which is how split accesses get concatenated.
  assign win = 32'(beat_data >> {lane, 3'b000});

  always_comb begin
    case (ctrl)
      CTRL_B, CTRL_BU: result = ext_byte(win[7:0], ctrl[2]);
      CTRL_H, CTRL_HU: result = ext_half(win[15:0], ctrl[2]);
      default:         result = win;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Converts one byte-addressed load/store request at a time into word accesses
// on a 2^MEM_AW-word data memory with byte enables and lane-steered write data,
// and returns extended load data through a one-cycle response pulse.
//
// Optional feature: define LSU_MISALIGNED_SPLIT_EN to split misaligned
// accesses (half at lane 3, word at nonzero lane) into two word beats; when
// undefined such accesses complete with rsp_err=1 and no memory write.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_we, req_ctrl       store select, size/sign code
//   req_addr, req_wdata    byte address, LSB-justified store data
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata, rsp_err     extended load data / error flag
//   mem_addr, mem_we       word address, write strobe
//   mem_be, mem_wdata      byte enables, lane-steered write data
//   mem_rdata              combinational read data for mem_addr
// -----------------------------------------------------------------------------
import lsu_pkg::*;

module load_store_unit #(
  parameter int          MEM_AW      = 6,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_ctrl,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t state, state_nxt;

  logic              we_p0;
  logic [2:0]        ctrl_p0;
  logic [MEM_AW+1:0] addr_p0;
  logic [31:0]       wdata_p0;
  logic [31:0]       lo_p1;

  logic [1:0]        lane;
  logic [MEM_AW-1:0] waddr;
  logic [7:0]        be64;
  logic [63:0]       wd64;
  logic [63:0]       wd64_m;
  logic              illegal;
  logic              misaligned;
  logic              split;
  logic              err_c;
  logic [63:0]       beat_data;
  logic [31:0]       align_out;
  logic              unused_addr_hi;

  // Address bits above the memory's word range do not take part.
  assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

  assign lane  = addr_p0[1:0];
  assign waddr = addr_p0[MEM_AW+1:2];

  // Enables and data laid out across two consecutive words: the low nibble /
  // low word is beat 1, the high nibble / high word is the spill into beat 2.
  assign be64 = {4'b0000, size_mask(ctrl_p0)} << lane;
  assign wd64 = {32'h0, wdata_p0} << {lane, 3'b000};

  always_comb begin
    wd64_m = '0;
    for (int i = 0; i < 8; i++) begin
      if (be64[i]) wd64_m[8*i +: 8] = wd64[8*i +: 8];
    end
  end

  assign illegal    = (size_mask(ctrl_p0) == 4'b0000) | (we_p0 & ctrl_p0[2]);
  assign misaligned = |be64[7:4];

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign split = misaligned & ~illegal;
  assign err_c = illegal;
`else
  assign split = 1'b0;
  assign err_c = illegal | misaligned;
`endif

  assign beat_data = (state == BEAT2) ? {mem_rdata, lo_p1} : {32'h0, mem_rdata};

  lsu_load_align u_align (
    .beat_data (beat_data),
    .lane      (lane),
    .ctrl      (ctrl_p0),
    .result    (align_out)
  );

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Memory-side outputs decode straight from state so a reset pulls the write
  // strobe low at once, before any further beat can land.
  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = BEAT1;
      end
      BEAT1: begin
        mem_addr = waddr;
        if (!err_c) begin
          mem_be    = be64[3:0];
          mem_we    = we_p0;
          mem_wdata = we_p0 ? wd64_m[31:0] : 32'h0;
        end
        state_nxt = split ? BEAT2 : RESP;
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      BEAT2: begin
        mem_addr  = waddr + MEM_AW'(1);
        mem_be    = be64[7:4];
        mem_we    = we_p0;
        mem_wdata = we_p0 ? wd64_m[63:32] : 32'h0;
        state_nxt = RESP;
      end
`endif
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p0: request capture on acceptance; p1: first-beat read word.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      we_p0    <= req_we;
      ctrl_p0  <= req_ctrl;
      addr_p0  <= req_addr[MEM_AW+1:0];
      wdata_p0 <= req_wdata;
    end
    if (state == BEAT1) lo_p1 <= mem_rdata;
  end

  // Response registers: load data lands at the end of the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= RESET_RDATA;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) rsp_err <= 1'b0;
        end
        BEAT1: begin
          rsp_err <= err_c;
          if (err_c || we_p0) rsp_rdata <= RESET_RDATA;
          else if (!split)    rsp_rdata <= align_out;
        end
        BEAT2: begin
          rsp_rdata <= we_p0 ? RESET_RDATA : align_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit. A byte-addressed reference memory models
// the expected effect of every request; the bench-owned word memory is the one
// the DUT actually reads and writes. Build with +define+LSU_MISALIGNED_SPLIT_EN
// to exercise the split path.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int          MEM_AW = 6;
  localparam logic [31:0] RST_RD = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_ctrl = 3'b000;
  logic [31:0]       req_addr = 32'h0;
  logic [31:0]       req_wdata = 32'h0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_AW(MEM_AW), .RESET_RDATA(RST_RD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Word memory seen by the DUT; initial byte value equals its byte address.
  logic [31:0] tmem [0:63];
  bit          tmem_loaded = 1'b0;
  assign mem_rdata = tmem[mem_addr];

  always @(posedge clk) begin
    if (!tmem_loaded) begin
      for (int b = 0; b < 256; b++) tmem[b/4][8*(b%4) +: 8] = 8'(b);
      tmem_loaded = 1'b1;
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) tmem[mem_addr][8*i +: 8] = mem_wdata[8*i +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int val);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired / no matching request (value %0d, t=%0t)", name, val, $time);
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nw;
    logic        st;
    logic [7:0]  addr;
    int          size;
    logic [31:0] wd;
    int          acc;
  } exp_t;

  exp_t       q[$];
  logic [7:0] rmem [0:255];
  bit         rmem_loaded = 1'b0;

  function automatic exp_t model(input logic we, input logic [2:0] ctrl,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input int acc);
    exp_t        e;
    int          size;
    logic        illegal, mis, split_ok;
    logic [31:0] v;
    size    = (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
    illegal = (ctrl == 3'b011) || (ctrl == 3'b110) || (ctrl == 3'b111) || (we && ctrl[2]);
    mis     = (size == 2 && addr[1:0] == 2'd3) || (size == 4 && addr[1:0] != 2'd0);
`ifdef LSU_MISALIGNED_SPLIT_EN
    split_ok = 1'b1;
`else
    split_ok = 1'b0;
`endif
    e.rdata = RST_RD; e.err = 1'b0; e.lat = 2; e.nw = 0; e.st = 1'b0;
    e.addr = addr[7:0]; e.size = size; e.wd = wd; e.acc = acc;
    if (illegal || (mis && !split_ok)) begin
      e.err = 1'b1;
    end else begin
      if (mis) e.lat = 3;
      if (we) begin
        e.st = 1'b1;
        e.nw = mis ? 2 : 1;
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = rmem[8'(addr[7:0] + 8'(i))];
        if (size == 1)      e.rdata = ctrl[2] ? v : {{24{v[7]}}, v[7:0]};
        else if (size == 2) e.rdata = ctrl[2] ? v : {{16{v[15]}}, v[15:0]};
        else                e.rdata = v;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // ---------------------------------------------------------------- compare
  int          wcnt = 0;
  int          last_rsp_cyc = -10;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;
  int          last_wcnt;
  logic [MEM_AW-1:0] w_addr [0:1];
  logic [3:0]        w_be   [0:1];
  logic [31:0]       w_wd   [0:1];
  logic [MEM_AW-1:0] last_waddr [0:1];
  logic [3:0]        last_wbe   [0:1];
  logic [31:0]       last_wwd   [0:1];

  always @(negedge clk) begin
    exp_t e;
    int   bad;
    if (rst) begin
      if (!rmem_loaded) begin
        for (int b = 0; b < 256; b++) rmem[b] = 8'(b);
        rmem_loaded = 1'b1;
      end
      wcnt = 0;
      q.delete();
    end else begin
      if (mem_we) begin
        chk("wdata_unselected_lanes", mem_wdata & ~lane_mask(mem_be), 32'h0);
        if (wcnt < 2) begin
          w_addr[wcnt] = mem_addr; w_be[wcnt] = mem_be; w_wd[wcnt] = mem_wdata;
        end
        wcnt++;
      end
      if (rsp_valid) begin
        last_rsp_cyc = cyc;
        if (q.size() == 0) begin
          fail_now("rsp_without_request", cyc);
        end else begin
          e = q.pop_front();
          if (e.st) for (int i = 0; i < e.size; i++) rmem[8'(e.addr + 8'(i))] = e.wd[8*i +: 8];
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("write_beats", 32'(wcnt), 32'(e.nw));
          chk("ready_low_in_resp", 32'(req_ready), 32'h0);
          bad = 0;
          for (int w = 0; w < 64; w++)
            if (tmem[w] !== {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]}) bad++;
          chk("mem_image_bad_words", 32'(bad), 32'h0);
          last_rdata = rsp_rdata; last_err = rsp_err;
          last_lat = cyc - e.acc; last_wcnt = wcnt;
          last_waddr = w_addr; last_wbe = w_be; last_wwd = w_wd;
        end
        wcnt = 0;
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic issue(input logic we, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wd);
    int n;
    int acc;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wd;
    while (!req_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail_now("accept_timeout", n);
      req_valid = 1'b0;
      return;
    end
    acc = cyc;
    if (n > 0) chk("back_to_back_accept_cycle", 32'(acc), 32'(last_rsp_cyc + 1));
    q.push_back(model(we, ctrl, addr, wd, acc));
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_ctrl = 3'b111; req_addr = ~addr; req_wdata = ~wd;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (q.size() != 0 && n < 30);
    if (q.size() != 0) fail_now("response_timeout", q.size());
  endtask

  logic [31:0] w0_snap, w63_snap;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, RST_RD);
    chk("reset_mem_we", 32'(mem_we), 32'h0);
    chk("reset_mem_be", 32'(mem_be), 32'h0);
    chk("reset_mem_addr", 32'(mem_addr), 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // Word store then signed byte load
    issue(1'b1, 3'b010, 32'h0000_0010, 32'h80FF_7F01);
    wait_idle();
    chk("st_word_err", 32'(last_err), 32'h0);
    chk("st_word_beats", 32'(last_wcnt), 32'h1);
    issue(1'b0, 3'b000, 32'h0000_0013, 32'h0);
    wait_idle();
    chk("ld_b_rdata", last_rdata, 32'hFFFF_FF80);
    chk("ld_b_latency", 32'(last_lat), 32'h2);
    chk("ld_b_err", 32'(last_err), 32'h0);

    // Zero-extended half
    issue(1'b0, 3'b101, 32'h0000_0012, 32'h0);
    wait_idle();
    chk("ld_hu_rdata", last_rdata, 32'h0000_80FF);

    // Half store at lane 2
    issue(1'b1, 3'b001, 32'h0000_0022, 32'h0000_ABCD);
    wait_idle();
    chk("st_h_beats", 32'(last_wcnt), 32'h1);
    chk("st_h_be", 32'(last_wbe[0]), 32'hC);
    chk("st_h_wdata", last_wwd[0], 32'hABCD_0000);
    chk("st_h_addr", 32'(last_waddr[0]), 32'h8);

    // Illegal: unsigned-coded store
    issue(1'b1, 3'b100, 32'h0000_0030, 32'h1234_5678);
    wait_idle();
    chk("illegal_beats", 32'(last_wcnt), 32'h0);
    chk("illegal_err", 32'(last_err), 32'h1);
    chk("illegal_rdata", last_rdata, 32'h0);

    // Misaligned word across the top of memory
    issue(1'b1, 3'b010, 32'h0000_00FE, 32'h1122_3344);
    wait_idle();
`ifdef LSU_MISALIGNED_SPLIT_EN
    chk("mis_st_err", 32'(last_err), 32'h0);
    chk("mis_st_beats", 32'(last_wcnt), 32'h2);
    chk("mis_st_latency", 32'(last_lat), 32'h3);
    chk("mis_st_addr1", 32'(last_waddr[0]), 32'd63);
    chk("mis_st_be1", 32'(last_wbe[0]), 32'hC);
    chk("mis_st_wd1", last_wwd[0], 32'h3344_0000);
    chk("mis_st_addr2", 32'(last_waddr[1]), 32'd0);
    chk("mis_st_be2", 32'(last_wbe[1]), 32'h3);
    chk("mis_st_wd2", last_wwd[1], 32'h0000_1122);
    issue(1'b0, 3'b010, 32'h0000_00FE, 32'h0);
    wait_idle();
    chk("mis_ld_rdata", last_rdata, 32'h1122_3344);
    chk("mis_ld_latency", 32'(last_lat), 32'h3);
`else
    chk("mis_st_err", 32'(last_err), 32'h1);
    chk("mis_st_beats", 32'(last_wcnt), 32'h0);
    issue(1'b0, 3'b010, 32'h0000_00FE, 32'h0);
    wait_idle();
    chk("mis_ld_err", 32'(last_err), 32'h1);
    chk("mis_ld_rdata", last_rdata, 32'h0);
`endif

    // Back-to-back burst, model-checked; req_valid stays high while busy
    issue(1'b1, 3'b000, 32'h0000_0040, 32'hFFFF_FF5A);
    issue(1'b1, 3'b000, 32'h0000_0041, 32'h1234_56A7);
    issue(1'b1, 3'b001, 32'h0000_0046, 32'h9999_8001);
    issue(1'b0, 3'b000, 32'h0000_0041, 32'h0);
    issue(1'b0, 3'b100, 32'h0000_0041, 32'h0);
    issue(1'b0, 3'b001, 32'h0000_0040, 32'h0);
    issue(1'b0, 3'b101, 32'h0000_0046, 32'h0);
    issue(1'b0, 3'b001, 32'h0000_0045, 32'h0);
    issue(1'b0, 3'b010, 32'h0000_0044, 32'h0);
    issue(1'b0, 3'b011, 32'h0000_0040, 32'h0);
    issue(1'b0, 3'b110, 32'h0000_0040, 32'h0);
    issue(1'b0, 3'b111, 32'h0000_0040, 32'h0);
    issue(1'b1, 3'b101, 32'h0000_0040, 32'hFFFF_FFFF);
    issue(1'b0, 3'b001, 32'h0000_0013, 32'h0);
    issue(1'b1, 3'b001, 32'h0000_0027, 32'h0000_BEEF);
    issue(1'b0, 3'b010, 32'h0000_0025, 32'h0);
    issue(1'b0, 3'b101, 32'h0000_0027, 32'h0);
    issue(1'b1, 3'b010, 32'h0000_002B, 32'hCAFE_F00D);
    issue(1'b0, 3'b010, 32'h0000_002B, 32'h0);
    issue(1'b0, 3'b000, 32'h1234_5603, 32'h0);
    wait_idle();

    // Reset during the first beat of a store
    w0_snap  = tmem[0];
    w63_snap = tmem[63];
`ifdef LSU_MISALIGNED_SPLIT_EN
    issue(1'b1, 3'b010, 32'h0000_00FE, 32'hDEAD_BEEF);
`else
    issue(1'b1, 3'b010, 32'h0000_0000, 32'hDEAD_BEEF);
`endif
    chk("beat1_we_before_rst", 32'(mem_we), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mem_we_drops", 32'(mem_we), 32'h0);
    chk("rst_no_rsp_valid", 32'(rsp_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'h1);
    chk("rdata_after_rst", rsp_rdata, RST_RD);
    chk("word0_unchanged", tmem[0], w0_snap);
    chk("word63_unchanged", tmem[63], w63_snap);

    // Operation resumes after the aborted request
    issue(1'b0, 3'b010, 32'h0000_0000, 32'h0);
    issue(1'b0, 3'b010, 32'h0000_00FC, 32'h0);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and a word-organised data memory.
- Accepts one byte-addressed load/store request at a time, using the funct3-style size/sign code of the data memory.
- Converts each request into word-addressed accesses with byte enables and write-data lane steering.
- Returns sign- or zero-extended load data through a valid/ready handshake, so the core can stall on multi-cycle accesses.

Parameters:
- MEM_AW, 6, word-address width of the data memory (64 words).
- RESET_RDATA, 32'h0000_0000, value held on rsp_rdata at reset and on error responses.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_ctrl  input  3  000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, LSB-justified.
- rsp_valid  output  1  one-cycle pulse when a request completes.
- rsp_rdata  output  32  extended load data; RESET_RDATA for stores and errors.
- rsp_err  output  1  qualified by rsp_valid; illegal ctrl or unsupported misalignment.
- mem_addr  output  MEM_AW  word address, taken from req_addr[MEM_AW+1:2].
- mem_we  output  1  write strobe, one cycle per beat.
- mem_be  output  4  byte enables, bit i selects bits [8i+7:8i].
- mem_wdata  output  32  lane-steered store data.
- mem_rdata  input  32  combinational read data for mem_addr.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=RESET_RDATA, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- FSM states are IDLE, BEAT1, BEAT2 and RESP.
  - IDLE: on req_valid, capture the request into registers and go to BEAT1.
  - BEAT1: drive the first word access; go to BEAT2 if the access is split, otherwise to RESP.
  - BEAT2: drive the second word access, then go to RESP.
  - RESP: pulse rsp_valid, then return to IDLE.
- Latency: an aligned access reaches rsp_valid 2 cycles after acceptance; a split access takes 3 cycles. req_ready is low from acceptance through RESP.
- Byte lane is req_addr[1:0]. Size is 1, 2 or 4 bytes, from ctrl[1:0].
- Stores: mem_be is the size mask shifted left by the lane. mem_wdata is req_wdata shifted left by 8×lane. Unselected lanes are don't-care but driven to 0.
- Loads:
  - Extract the byte or half at the lane from mem_rdata, registered at the end of the beat.
  - ctrl[2]=0: sign-extend. ctrl[2]=1: zero-extend.
  - Word loads pass through unchanged.
- Illegal encodings, checked in BEAT1 with no memory write (mem_we=0) and rsp_err=1:
  - ctrl 011, 110 or 111;
  - a store with ctrl[2]=1.
- Misalignment:
  - Defined as a half at lane 3, or a word at a nonzero lane.
  - Handling depends on the optional feature below.
- Wrap-around: for the second beat of a split, mem_addr is incremented modulo 2^MEM_AW (word 63 wraps to 0).
- Back-to-back: a new request is accepted in the IDLE cycle immediately after RESP. req_valid seen in any other state is ignored.
- Reset mid-operation: returns to IDLE immediately. mem_we drops asynchronously, so no partial second beat is written. No rsp_valid is generated for the aborted request.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined:
  - A misaligned access is split into BEAT1 (the low word, upper lanes from the lane onward) and BEAT2 (the next word, remaining low lanes).
  - Load bytes from the two beats are concatenated before extension.
  - rsp_err=0.
- Undefined:
  - A misaligned access performs no memory write.
  - It goes from BEAT1 straight to RESP with rsp_err=1 and rsp_rdata=RESET_RDATA.
  - BEAT2 is unreachable and may be compiled out.

Decomposition:
- Package lsu_pkg holds:
  - localparams for the ctrl codes CTRL_B, CTRL_H, CTRL_W, CTRL_BU, CTRL_HU;
  - the state enum type lsu_state_t;
  - function size_mask(ctrl) returning the 4-bit unshifted byte-enable mask.
- One sub-module, lsu_load_align: combinational. Inputs are the raw 64-bit beat data, lane and ctrl; output is the 32-bit extended result. It is shared by the aligned and split paths.

Test Plan:
- Reset, then load byte: store word 32'h80FF_7F01 at addr 0x10; load ctrl=000 from addr 0x13 -> rsp_rdata=32'hFFFF_FF80, rsp_valid 2 cycles after acceptance, rsp_err=0.
- Zero-extend half: same memory contents; load ctrl=101 from addr 0x12 -> rsp_rdata=32'h0000_80FF.
- Store half at lane 2: addr 0x22, wdata=32'h0000_ABCD, ctrl=001 -> mem_be=4'b1100, mem_wdata=32'hABCD_0000, mem_addr=8, mem_we for exactly 1 cycle.
- Illegal ctrl: store with ctrl=100 -> mem_we never asserts; rsp_err=1, rsp_rdata=0.
- Misaligned word: store 32'h1122_3344 at addr 0xFE.
  - With the macro: beat 1 has mem_addr=63, be=1100; beat 2 has mem_addr=0, be=0011. A reload of 0xFE returns 32'h1122_3344.
  - Without the macro: rsp_err=1 and no write.
- Reset mid-split: assert rst during BEAT1 of a split store -> mem_we low immediately, req_ready=1 after release, word 0 unchanged.
